frame_upload_datapath: RTL and testbench
========================================

Name: frame_upload_datapath

Overview:
- Datapath block for the frame uploader FSM.
- Contains a simple dual-port mixed-width line cache: 16-bit write port, 32-bit read port, 16 x 16-bit storage.
- Contains a registered address adder: 21-bit base plus 11-bit increment, 22-bit result.
- The FSM fills the cache from the pixel queue, drains it as 32-bit burst words to memory, and advances the frame address with the adder.

Parameters:
- WR_DEPTH, 16, number of 16-bit cache entries (write-port depth; power of two).
- WR_WIDTH, 16, write-port data width.
- RD_WIDTH, 32, read-port data width (2 x WR_WIDTH).
- A_WIDTH, 21, adder operand A width.
- B_WIDTH, 11, adder operand B width (zero-extended to A_WIDTH).

Ports:
- clk in 1: single clock for both cache ports and the adder.
- reset in 1: asynchronous, active-high reset.
- cache_we in 1: write-port enable.
- cache_waddr in 4: 16-bit entry address.
- cache_wdata in 16: write data.
- cache_re in 1: read-port enable.
- cache_raddr in 3: 32-bit word address.
- cache_oce in 1: output-register clock enable (used only with the optional feature).
- cache_rdata out 32: read data.
- add_ce in 1: adder clock enable.
- add_a in 21: operand A.
- add_b in 11: operand B.
- add_sum out 22: registered A+B.
- add_caso out 55: cascade output, registered, equal to {33'd0, add_sum}.

Behaviour:
- Reset values: cache_rdata = 0, add_sum = 0, add_caso = 0. Memory array is NOT reset; contents are undefined until written. Reset mid-operation clears the outputs immediately, and no write or read occurs while reset is high.
- Write: at a clk rising edge with cache_we=1, mem[cache_waddr] <= cache_wdata. No write when cache_we=0.
- Read: at a clk rising edge with cache_re=1, cache_rdata <= {mem[2*cache_raddr+1], mem[2*cache_raddr]}; the lower address occupies bits [15:0]. One-cycle latency. cache_rdata holds its value when cache_re=0.
- Read and write to overlapping entries in the same cycle: read returns the old data (read-before-write). The new data is visible on the next read.
- Back-to-back reads: a new raddr every cycle yields a new word every cycle after the 1-cycle latency, with no bubbles.
- Adder: at a clk rising edge with add_ce=1, add_sum <= {1'b0, add_a} + {11'b0, add_b}, computed at full 22 bits so the carry lands in bit 21. add_sum holds when add_ce=0. Operands are sampled at the enable edge.
- Adder overflow: 21'h1FFFFF + 1 gives 22'h200000 (no wrap inside 22 bits).
- No internal FSM. The block is purely registered storage and arithmetic.

Optional Feature:
- Macro CACHE_OUTREG_EN.
- When defined: a second output register is placed after the read register and loaded when cache_oce=1, giving 2-cycle read latency. Reset clears both registers.
- When undefined: cache_oce is ignored (bypass mode), giving 1-cycle read latency.
- Adder behaviour is identical in both builds.

Decomposition:
- Shared package frame_upload_pkg holds:
  - localparams CACHE_WR_DEPTH=16, CACHE_RD_DEPTH=8, CACHE_WR_W=16, CACHE_RD_W=32, ADDR_W=21, SUM_W=22;
  - typedef cache_waddr_t (4-bit) and cache_raddr_t (3-bit).
- One natural sub-module: frame_line_cache, the mixed-width SDP memory with its output register(s).
- The adder stays inline in the top block.

Test Plan:
- Reset mid-operation: write entries, start reads and adds, then pulse reset async between edges -> cache_rdata, add_sum and add_caso go to 0 immediately; after release, reading entries written before the reset returns their previously written data.
- Fill then drain: write entries 0..15 with 16'h0100+i, then read raddr 0..7 back-to-back -> word k equals {16'h0100+2k+1, 16'h0100+2k}, e.g. raddr 3 gives 32'h01070106, each 1 cycle after its address.
- Collision: mem[4]=16'hAAAA; write 16'h5555 to entry 4 while reading raddr 2 in the same cycle -> low half reads 16'hAAAA; the next read of raddr 2 returns 16'h5555 in the low half.
- Hold behaviour: cache_re=0 and add_ce=0 for 5 cycles while the inputs change -> cache_rdata and add_sum unchanged.
- Adder: a=21'h000100, b=11'd16, ce=1 -> add_sum=22'h000110 next cycle. a=21'h1FFFFF, b=1 -> 22'h200000, and add_caso equals the zero-extended add_sum.
- CACHE_OUTREG_EN build: read raddr 1 with cache_oce=1 -> data appears after 2 cycles. With cache_oce=0 the output holds its previous value.

Source files
------------

// File: rtl/frame_upload_pkg.sv
// -----------------------------------------------------------------------------
// frame_upload_pkg
// Shared constants and types for the frame uploader datapath.
//   - Line cache geometry: 16 x 16-bit write entries, read back as 8 x 32-bit
//     words.
//   - Address adder widths: 21-bit base, 22-bit sum, 55-bit cascade output.
// -----------------------------------------------------------------------------
package frame_upload_pkg;

   localparam int CACHE_WR_DEPTH = 16;
   localparam int CACHE_RD_DEPTH = 8;
   localparam int CACHE_WR_W     = 16;
   localparam int CACHE_RD_W     = 32;
   localparam int ADDR_W         = 21;
   localparam int INCR_W         = 11;
   localparam int SUM_W          = 22;
   localparam int CASO_W         = 55;

   typedef logic [$clog2(CACHE_WR_DEPTH)-1:0] cache_waddr_t;
   typedef logic [$clog2(CACHE_RD_DEPTH)-1:0] cache_raddr_t;

endpackage

// File: rtl/frame_line_cache.sv
// -----------------------------------------------------------------------------
// frame_line_cache
// Simple dual-port, mixed-width line cache. Narrow write port, wide read port
// (RD_WIDTH = 2 x WR_WIDTH by default). A wide word k is built from narrow
// entries {2k+1, 2k}, with the lower entry in the low half.
//
// Build option: define CACHE_OUTREG_EN to add a second output register loaded
// by oce (2-cycle read latency). Undefined: oce is ignored, 1-cycle latency.
//
// Ports:
//   clk, reset       single clock, asynchronous active-high reset
//   we, waddr, wdata narrow write port
//   re, raddr        wide read port enable / word address
//   oce              output-register enable (CACHE_OUTREG_EN build only)
//   rdata            registered wide read data
// -----------------------------------------------------------------------------
module frame_line_cache
   import frame_upload_pkg::*;
#(
   parameter int WR_DEPTH = CACHE_WR_DEPTH,
   parameter int WR_WIDTH = CACHE_WR_W,
   parameter int RD_WIDTH = CACHE_RD_W
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          we,
   input  logic [$clog2(WR_DEPTH)-1:0]   waddr,
   input  logic [WR_WIDTH-1:0]           wdata,
   input  logic                          re,
   input  logic [$clog2(WR_DEPTH)-$clog2(RD_WIDTH/WR_WIDTH)-1:0] raddr,
   input  logic                          oce,
   output logic [RD_WIDTH-1:0]           rdata
);

   localparam int RATIO  = RD_WIDTH / WR_WIDTH;
   localparam int LANE_W = $clog2(RATIO);

   // Storage is deliberately not reset so it maps onto block RAM.
   logic [WR_WIDTH-1:0] mem_q [WR_DEPTH];
   logic [RD_WIDTH-1:0] rd_word;
   logic [RD_WIDTH-1:0] rdata_d;
   logic [RD_WIDTH-1:0] rdata_q;

   // Writes are suppressed while reset is asserted even though the array
   // itself keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (we && !reset) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Each read lane picks one narrow entry; lane 0 is the lowest address.
   for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign rd_word[gi*WR_WIDTH +: WR_WIDTH] = mem_q[{raddr, LANE_W'(gi)}];
   end

   // Read register samples the array before this edge's write lands,
   // giving read-before-write on colliding addresses.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = rd_word;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

`ifdef CACHE_OUTREG_EN
   logic [RD_WIDTH-1:0] dout_d;
   logic [RD_WIDTH-1:0] dout_q;

   always_comb begin
      dout_d = dout_q;
      if (oce) begin
         dout_d = rdata_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign rdata = dout_q;
`else
   // Bypass mode: output register absent, enable has no effect.
   logic unused_oce;
   assign unused_oce = oce;
   assign rdata      = rdata_q;
`endif

endmodule

// File: rtl/frame_upload_datapath.sv
// -----------------------------------------------------------------------------
// frame_upload_datapath
// Datapath for the frame uploader: a mixed-width line cache (16-bit in,
// 32-bit out) and a registered frame-address adder. No control logic lives
// here; the uploader FSM drives all enables.
//
// Build option: CACHE_OUTREG_EN adds a cache output register (2-cycle read
// latency, gated by cache_oce). The adder is the same in both builds.
//
// Ports:
//   clk, reset                         single clock, async active-high reset
//   cache_we, cache_waddr, cache_wdata 16-bit cache write port
//   cache_re, cache_raddr, cache_rdata 32-bit cache read port
//   cache_oce                          cache output-register enable
//   add_ce, add_a, add_b               adder enable and operands
//   add_sum                            registered a + b (carry in MSB)
//   add_caso                           registered zero-extended add_sum
// -----------------------------------------------------------------------------
module frame_upload_datapath
   import frame_upload_pkg::*;
#(
   parameter int WR_DEPTH = CACHE_WR_DEPTH,
   parameter int WR_WIDTH = CACHE_WR_W,
   parameter int RD_WIDTH = CACHE_RD_W,
   parameter int A_WIDTH  = ADDR_W,
   parameter int B_WIDTH  = INCR_W
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              cache_we,
   input  logic [$clog2(WR_DEPTH)-1:0]       cache_waddr,
   input  logic [WR_WIDTH-1:0]               cache_wdata,
   input  logic                              cache_re,
   input  logic [$clog2(WR_DEPTH)-$clog2(RD_WIDTH/WR_WIDTH)-1:0] cache_raddr,
   input  logic                              cache_oce,
   output logic [RD_WIDTH-1:0]               cache_rdata,
   input  logic                              add_ce,
   input  logic [A_WIDTH-1:0]                add_a,
   input  logic [B_WIDTH-1:0]                add_b,
   output logic [A_WIDTH:0]                  add_sum,
   output logic [CASO_W-1:0]                 add_caso
);

   frame_line_cache #(
      .WR_DEPTH (WR_DEPTH),
      .WR_WIDTH (WR_WIDTH),
      .RD_WIDTH (RD_WIDTH)
   ) u_cache (
      .clk   (clk),
      .reset (reset),
      .we    (cache_we),
      .waddr (cache_waddr),
      .wdata (cache_wdata),
      .re    (cache_re),
      .raddr (cache_raddr),
      .oce   (cache_oce),
      .rdata (cache_rdata)
   );

   // Adder works at A_WIDTH+1 bits so the carry out lands in the sum MSB.
   logic [A_WIDTH:0]    add_b_ext;
   logic [A_WIDTH:0]    add_sum_d;
   logic [A_WIDTH:0]    add_sum_q;
   logic [CASO_W-1:0]   add_caso_d;
   logic [CASO_W-1:0]   add_caso_q;

   assign add_b_ext = {{(A_WIDTH + 1 - B_WIDTH){1'b0}}, add_b};

   always_comb begin
      add_sum_d  = add_sum_q;
      add_caso_d = add_caso_q;
      if (add_ce) begin
         add_sum_d  = {1'b0, add_a} + add_b_ext;
         add_caso_d = {{(CASO_W - A_WIDTH - 1){1'b0}}, add_sum_d};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         add_sum_q  <= '0;
         add_caso_q <= '0;
      end else begin
         add_sum_q  <= add_sum_d;
         add_caso_q <= add_caso_d;
      end
   end

   assign add_sum  = add_sum_q;
   assign add_caso = add_caso_q;

endmodule

// File: tb/tb_frame_upload_datapath.sv
// -----------------------------------------------------------------------------
// tb_frame_upload_datapath
// Directed self-checking bench for frame_upload_datapath. Inputs change on
// the falling edge; outputs are sampled 1 ns after the rising edge.
// Read latency follows the CACHE_OUTREG_EN build option.
// -----------------------------------------------------------------------------
module tb_frame_upload_datapath;

`ifdef CACHE_OUTREG_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cache_we;
   logic [3:0]  cache_waddr;
   logic [15:0] cache_wdata;
   logic        cache_re;
   logic [2:0]  cache_raddr;
   logic        cache_oce;
   logic [31:0] cache_rdata;
   logic        add_ce;
   logic [20:0] add_a;
   logic [10:0] add_b;
   logic [21:0] add_sum;
   logic [54:0] add_caso;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   frame_upload_datapath dut (
      .clk         (clk),
      .reset       (reset),
      .cache_we    (cache_we),
      .cache_waddr (cache_waddr),
      .cache_wdata (cache_wdata),
      .cache_re    (cache_re),
      .cache_raddr (cache_raddr),
      .cache_oce   (cache_oce),
      .cache_rdata (cache_rdata),
      .add_ce      (add_ce),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_sum     (add_sum),
      .add_caso    (add_caso)
   );

   // Stimulus drivers only; comparisons stay in the test tasks.
   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      cache_we = 1'b1; cache_waddr = a; cache_wdata = d;
      @(posedge clk); #1;
      cache_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] ra, input logic w_en, input logic [3:0] wa,
                     input logic [15:0] wd, output logic [31:0] data);
      @(negedge clk);
      cache_re = 1'b1; cache_raddr = ra;
      cache_we = w_en; cache_waddr = wa; cache_wdata = wd;
      for (int i = 0; i < RD_LAT; i++) begin
         @(posedge clk); #1;
         cache_re = 1'b0; cache_we = 1'b0;
      end
      data = cache_rdata;
   endtask

   task automatic add(input logic [20:0] a, input logic [10:0] b);
      @(negedge clk);
      add_ce = 1'b1; add_a = a; add_b = b;
      @(posedge clk); #1;
      add_ce = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      cache_we = 0; cache_waddr = 0; cache_wdata = 0;
      cache_re = 0; cache_raddr = 0; cache_oce = 1'b1;
      add_ce = 0; add_a = 0; add_b = 0;
      #1;
      checks++; if (cache_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp %h", cache_rdata, 32'h0); end
      checks++; if (add_sum !== 22'h0) begin errors++; $display("FAIL reset_sum got %h exp %h", add_sum, 22'h0); end
      checks++; if (add_caso !== 55'h0) begin errors++; $display("FAIL reset_caso got %h exp %h", add_caso, 55'h0); end
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      $display("reset: rdata=%h sum=%h caso=%h", cache_rdata, add_sum, add_caso);
   endtask

   task automatic test_fill_drain;
      logic [31:0] exp;
      for (int i = 0; i < 16; i++) wr(4'(i), 16'h0100 + 16'(i));
      // One new address per cycle; word k appears RD_LAT edges after issue.
      for (int c = 0; c < 8 + RD_LAT - 1; c++) begin
         @(negedge clk);
         if (c < 8) begin cache_re = 1'b1; cache_raddr = 3'(c); end
         else cache_re = 1'b0;
         @(posedge clk); #1;
         if (c >= RD_LAT - 1) begin
            int k;
            k = c - (RD_LAT - 1);
            exp = {16'h0100 + 16'(2*k + 1), 16'h0100 + 16'(2*k)};
            checks++;
            if (cache_rdata !== exp) begin errors++; $display("FAIL drain_word%0d got %h exp %h", k, cache_rdata, exp); end
            $display("drain: raddr=%0d rdata=%h", k, cache_rdata);
         end
      end
      @(negedge clk); cache_re = 1'b0;
   endtask

   task automatic test_collision;
      logic [31:0] d;
      wr(4'd4, 16'hAAAA);
      rd(3'd2, 1'b1, 4'd4, 16'h5555, d);
      checks++; if (d !== 32'h0105AAAA) begin errors++; $display("FAIL collide_old got %h exp %h", d, 32'h0105AAAA); end
      $display("collision: same-cycle read=%h", d);
      rd(3'd2, 1'b0, 4'd0, 16'h0, d);
      checks++; if (d !== 32'h01055555) begin errors++; $display("FAIL collide_new got %h exp %h", d, 32'h01055555); end
      $display("collision: next read=%h", d);
   endtask

   task automatic test_adder;
      add(21'h000100, 11'd16);
      checks++; if (add_sum !== 22'h000110) begin errors++; $display("FAIL add_basic got %h exp %h", add_sum, 22'h000110); end
      checks++; if (add_caso !== 55'h000110) begin errors++; $display("FAIL caso_basic got %h exp %h", add_caso, 55'h000110); end
      $display("adder: 100+16 sum=%h", add_sum);
      add(21'h1FFFFF, 11'd1);
      checks++; if (add_sum !== 22'h200000) begin errors++; $display("FAIL add_carry got %h exp %h", add_sum, 22'h200000); end
      checks++; if (add_caso !== 55'h200000) begin errors++; $display("FAIL caso_carry got %h exp %h", add_caso, 55'h200000); end
      $display("adder: 1FFFFF+1 sum=%h caso=%h", add_sum, add_caso);
      add(21'h1FFFFF, 11'h7FF);
      checks++; if (add_sum !== 22'h2007FE) begin errors++; $display("FAIL add_max got %h exp %h", add_sum, 22'h2007FE); end
      $display("adder: 1FFFFF+7FF sum=%h", add_sum);
   endtask

   task automatic test_hold;
      logic [31:0] d0;
      add(21'h012345, 11'h021);
      rd(3'd6, 1'b0, 4'd0, 16'h0, d0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cache_re = 1'b0; cache_raddr = 3'(i);
         add_ce = 1'b0; add_a = 21'(i * 777 + 5); add_b = 11'(i + 9);
         @(posedge clk); #1;
         checks++; if (cache_rdata !== 32'h010D010C) begin errors++; $display("FAIL hold_rdata%0d got %h exp %h", i, cache_rdata, 32'h010D010C); end
         checks++; if (add_sum !== 22'h012366) begin errors++; $display("FAIL hold_sum%0d got %h exp %h", i, add_sum, 22'h012366); end
         $display("hold: cycle %0d rdata=%h sum=%h", i, cache_rdata, add_sum);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      add(21'h000ABC, 11'd1);
      rd(3'd3, 1'b0, 4'd0, 16'h0, d);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      checks++; if (cache_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got %h exp %h", cache_rdata, 32'h0); end
      checks++; if (add_sum !== 22'h0) begin errors++; $display("FAIL midrst_sum got %h exp %h", add_sum, 22'h0); end
      checks++; if (add_caso !== 55'h0) begin errors++; $display("FAIL midrst_caso got %h exp %h", add_caso, 55'h0); end
      // Enables asserted during reset must have no effect.
      @(negedge clk);
      cache_we = 1'b1; cache_waddr = 4'd0; cache_wdata = 16'hFFFF;
      cache_re = 1'b1; cache_raddr = 3'd0; add_ce = 1'b1; add_a = 21'h55; add_b = 11'h1;
      @(posedge clk); #1;
      checks++; if (cache_rdata !== 32'h0) begin errors++; $display("FAIL inrst_rdata got %h exp %h", cache_rdata, 32'h0); end
      checks++; if (add_sum !== 22'h0) begin errors++; $display("FAIL inrst_sum got %h exp %h", add_sum, 22'h0); end
      @(negedge clk);
      reset = 1'b0; cache_we = 1'b0; cache_re = 1'b0; add_ce = 1'b0;
      $display("reset_mid: outputs cleared rdata=%h sum=%h", cache_rdata, add_sum);
      rd(3'd3, 1'b0, 4'd0, 16'h0, d);
      checks++; if (d !== 32'h01070106) begin errors++; $display("FAIL postrst_r3 got %h exp %h", d, 32'h01070106); end
      rd(3'd0, 1'b0, 4'd0, 16'h0, d);
      checks++; if (d !== 32'h01010100) begin errors++; $display("FAIL postrst_r0 got %h exp %h", d, 32'h01010100); end
      $display("reset_mid: post-reset raddr0=%h", d);
   endtask

   task automatic test_outreg;
`ifdef CACHE_OUTREG_EN
      @(negedge clk);
      cache_oce = 1'b1; cache_re = 1'b1; cache_raddr = 3'd1;
      @(posedge clk); #1;
      cache_re = 1'b0;
      checks++; if (cache_rdata !== 32'h01010100) begin errors++; $display("FAIL oreg_lat1 got %h exp %h", cache_rdata, 32'h01010100); end
      @(posedge clk); #1;
      checks++; if (cache_rdata !== 32'h01030102) begin errors++; $display("FAIL oreg_lat2 got %h exp %h", cache_rdata, 32'h01030102); end
      @(negedge clk);
      cache_oce = 1'b0; cache_re = 1'b1; cache_raddr = 3'd7;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cache_rdata !== 32'h01030102) begin errors++; $display("FAIL oreg_hold got %h exp %h", cache_rdata, 32'h01030102); end
      @(negedge clk); cache_re = 1'b0; cache_oce = 1'b1;
`else
      // Bypass build: cache_oce low must not stall the 1-cycle read path.
      @(negedge clk);
      cache_oce = 1'b0; cache_re = 1'b1; cache_raddr = 3'd1;
      @(posedge clk); #1;
      cache_re = 1'b0;
      checks++; if (cache_rdata !== 32'h01030102) begin errors++; $display("FAIL bypass_oce got %h exp %h", cache_rdata, 32'h01030102); end
      @(negedge clk); cache_oce = 1'b1;
`endif
      $display("outreg: rdata=%h", cache_rdata);
   endtask

   initial begin
      test_reset;
      test_fill_drain;
      test_collision;
      test_adder;
      test_hold;
      test_reset_mid;
      test_outreg;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
